pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Program-counter register plus next-PC selection for the single-cycle MIPS datapath.
- Sits directly downstream of the immediate extender. In branch mode (EOp=2'b11) the extender outputs the sign-extended word offset already shifted left by 2; this block consumes that value.
- This block feeds the instruction memory address and the jal link path.
- Adds stall support, a sticky fault state for illegal fetch addresses, and a retired-instruction counter.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_DEPTH, 1024, number of 32-bit words in instruction memory.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  1 = advance PC this cycle; 0 = stall (PC and counter hold).
- npc_op  input  3  next-PC select: 000 seq, 001 beq, 010 bne, 011 j/jal, 100 jr; 101-111 reserved, treated as seq.
- ext_imm  input  32  branch offset from the extender, already <<2.
- instr_index  input  26  jump field instr[25:0].
- rs_val  input  32  GPR[rs]; used for compare and for the jr target.
- rt_val  input  32  GPR[rt]; used for compare.
- pc  output  32  current fetch address.
- pc_plus4  output  32  pc + 4; also the jal link value.
- npc  output  32  combinational next PC.
- branch_taken  output  1  combinational; beq/bne condition met.
- fault  output  1  sticky; an illegal next PC was detected.
- retired  output  32  count of instructions that advanced the PC.

Behaviour:
- Reset (async, rst_n=0):
  - pc = PC_RESET, fault = 0, retired = 0, state = RUN.
  - Takes effect immediately, mid-cycle included, and overrides everything.
- Combinational arithmetic (all additions mod 2^32, wrap silently):
  - pc_plus4 = pc + 4.
  - Branch target = pc_plus4 + ext_imm.
  - Jump target = {pc_plus4[31:28], instr_index, 2'b00}.
  - jr target = rs_val.
- branch_taken:
  - beq: (rs_val == rt_val).
  - bne: (rs_val != rt_val).
  - 0 for every other npc_op.
- npc:
  - Branch target if branch_taken.
  - Jump target for 011.
  - rs_val for 100.
  - pc_plus4 otherwise, including an untaken branch.
- illegal = (npc[1:0] != 0) OR (npc < IM_BASE) OR (npc >= IM_BASE + 4*IM_DEPTH). Compare unsigned, with the bound computed at 33 bits so there is no overflow.
- FSM states: RUN, FAULT.
  - RUN, en=1, not illegal: pc <= npc; retired <= retired + 1.
  - RUN, en=1, illegal: go to FAULT; pc holds; fault <= 1; retired does not increment.
  - RUN, en=0: everything holds; illegal is ignored (no fault is raised while stalled).
  - FAULT: pc, retired and fault=1 hold regardless of en or npc_op. The only exit is rst_n=0.
- Latency:
  - npc, pc_plus4 and branch_taken are zero-latency combinational outputs.
  - pc updates on the rising edge after npc is valid.
  - fault rises on the edge at which the illegal transfer would have occurred.
- retired wraps from 32'hFFFF_FFFF to 0 without affecting any other output.
- Reserved npc_op values: identical to seq; never raise fault by themselves.
- Simultaneous events:
  - rst_n low on a clock edge: reset wins.
  - en=0 with an illegal npc: no fault.

Test Plan:
1. Reset, then 3 cycles with en=1, npc_op=000 -> pc = 3000, 3004, 3008, 300C; retired = 3; fault = 0.
2. pc=3010, npc_op=001, rs_val=rt_val=5, ext_imm=32'hFFFF_FFF8 (offset -2 words) -> branch_taken=1, npc=300C, pc=300C next cycle. Same with rt_val=6 -> branch_taken=0, pc=3014.
3. pc=3000, npc_op=011, instr_index=26'h0000C05 -> npc=3014; pc=3014 next edge.
4. npc_op=100, rs_val=32'h0000_3002 (misaligned) -> fault=1, pc holds at its value, retired frozen. Further cycles with legal npc -> still held. rst_n pulse -> pc=3000, fault=0.
5. npc_op=100, rs_val=32'h0000_4000 (= IM_BASE + 4096, out of range) -> fault. rs_val=32'h0000_3FFC -> legal, pc=3FFC.
6. en=0 for 4 cycles with npc_op=011 -> pc and retired unchanged. Assert rst_n=0 between clock edges -> pc=3000 immediately, before the next edge.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: program counter and next-PC selection for the single-cycle MIPS
// datapath. It adds stall support, a sticky fault on illegal fetch targets,
// and a retired-instruction counter.
module pc_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_DEPTH = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic [2:0]  i_npc_op,
  input  logic [31:0] i_ext_imm,
  input  logic [25:0] i_instr_index,
  input  logic [31:0] i_rs_val,
  input  logic [31:0] i_rt_val,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_npc,
  output logic        o_branch_taken,
  output logic        o_fault,
  output logic [31:0] o_retired
);

  // npc_op encodings; 101-111 fall through to sequential
  localparam logic [2:0] OP_SEQ = 3'b000;
  localparam logic [2:0] OP_BEQ = 3'b001;
  localparam logic [2:0] OP_BNE = 3'b010;
  localparam logic [2:0] OP_J   = 3'b011;
  localparam logic [2:0] OP_JR  = 3'b100;

  // One-past-the-end fetch address. It is computed at 33 bits so that a
  // window reaching 2^32 does not wrap to a small value.
  localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_DEPTH) << 2);

  typedef enum logic {S_RUN, S_FAULT} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_retired, w_retired_nxt;
  logic        r_fault, w_fault_nxt;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_target;
  logic [31:0] w_j_target;
  logic [31:0] w_npc;
  logic        w_taken;
  logic        w_illegal;

  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_br_target = w_pc_plus4 + i_ext_imm;
  assign w_j_target  = {w_pc_plus4[31:28], i_instr_index, 2'b00};

  // Branch condition. Only beq and bne can assert it.
  always_comb begin
    w_taken = 1'b0;
    case (i_npc_op)
      OP_BEQ:  w_taken = (i_rs_val == i_rt_val);
      OP_BNE:  w_taken = (i_rs_val != i_rt_val);
      default: w_taken = 1'b0;
    endcase
  end

  // Next-PC select. An untaken branch and the reserved ops use pc+4.
  always_comb begin
    w_npc = w_pc_plus4;
    if (w_taken)               w_npc = w_br_target;
    else if (i_npc_op == OP_J)  w_npc = w_j_target;
    else if (i_npc_op == OP_JR) w_npc = i_rs_val;
  end

  // A target is illegal if it is misaligned or outside the instruction-memory window.
  assign w_illegal = (w_npc[1:0] != 2'b00) ||
                     (w_npc < IM_BASE) ||
                     ({1'b0, w_npc} >= IM_LIMIT);

  // Next-state logic. A stall ignores the illegal flag, and FAULT can only be left by reset.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_retired_nxt = r_retired;
    w_fault_nxt   = r_fault;
    case (r_state)
      S_RUN: begin
        if (i_en) begin
          if (w_illegal) begin
            w_state_nxt = S_FAULT;
            w_fault_nxt = 1'b1;
          end else begin
            w_pc_nxt      = w_npc;
            w_retired_nxt = r_retired + 32'd1;
          end
        end
      end
      S_FAULT: w_fault_nxt = 1'b1;
      default: w_state_nxt = S_FAULT;
    endcase
  end

  // State register. The asynchronous reset overrides everything else.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_RUN;
      r_pc      <= PC_RESET;
      r_retired <= 32'd0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_retired <= w_retired_nxt;
      r_fault   <= w_fault_nxt;
    end
  end

  assign o_pc           = r_pc;
  assign o_pc_plus4     = w_pc_plus4;
  assign o_npc          = w_npc;
  assign o_branch_taken = w_taken;
  assign o_fault        = r_fault;
  assign o_retired      = r_retired;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scenarios plus randomized traffic. All results are
// checked against a transaction-level reference model kept in this bench.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  npc_op = 3'd0;
  logic [31:0] ext_imm = 32'd0;
  logic [25:0] instr_index = 26'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic [31:0] pc, pc_plus4, npc, retired;
  logic        branch_taken, fault;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic        m_fault;

  pc_unit dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_npc_op(npc_op),
    .i_ext_imm(ext_imm), .i_instr_index(instr_index),
    .i_rs_val(rs_val), .i_rt_val(rt_val),
    .o_pc(pc), .o_pc_plus4(pc_plus4), .o_npc(npc),
    .o_branch_taken(branch_taken), .o_fault(fault), .o_retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected branch decision, computed from the instruction semantics
  function automatic logic ref_taken();
    if (npc_op == 3'd1) return rs_val == rt_val;
    if (npc_op == 3'd2) return rs_val != rt_val;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_npc();
    logic [31:0] p4;
    p4 = m_pc + 32'd4;
    if (ref_taken()) return p4 + ext_imm;
    case (npc_op)
      3'd3:    return {p4[31:28], instr_index, 2'b00};
      3'd4:    return rs_val;
      default: return p4;
    endcase
  endfunction

  function automatic logic ref_illegal(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || (a >= 32'h4000);
  endfunction

  // One rising edge. The model advances from the inputs that were present at the edge.
  task automatic tick();
    logic [31:0] t;
    t = ref_npc();
    @(posedge clk);
    if (en && !m_fault) begin
      if (ref_illegal(t)) m_fault = 1'b1;
      else begin m_pc = t; m_ret = m_ret + 1; end
    end
    #1;
  endtask

  task automatic drive(input logic e, input logic [2:0] op, input logic [31:0] imm,
                       input logic [25:0] idx, input logic [31:0] rs, input logic [31:0] rt);
    en = e; npc_op = op; ext_imm = imm; instr_index = idx; rs_val = rs; rt_val = rt;
  endtask

  // Reset pulse that asserts and releases between clock edges
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_pc = 32'h3000; m_ret = 0; m_fault = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b0, 3'd0, 32'd0, 26'd0, 32'd0, 32'd0);
    #1;
    n_tests++; if (pc !== 32'h3000) begin n_fail++; $display("FAIL reset_pc got %h exp 00003000", pc); end
    n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got %b exp 0", fault); end
    n_tests++; if (retired !== 32'd0) begin n_fail++; $display("FAIL reset_retired got %0d exp 0", retired); end
    n_tests++; if (pc_plus4 !== 32'h3004) begin n_fail++; $display("FAIL reset_pc_plus4 got %h exp 00003004", pc_plus4); end
  endtask

  task automatic test_seq();
    logic [31:0] exp_pc [3];
    exp_pc = '{32'h3004, 32'h3008, 32'h300C};
    do_reset();
    drive(1'b1, 3'd0, 32'd0, 26'd0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (pc !== exp_pc[i]) begin n_fail++; $display("FAIL seq_pc[%0d] got %h exp %h", i, pc, exp_pc[i]); end
    end
    n_tests++; if (retired !== 32'd3) begin n_fail++; $display("FAIL seq_retired got %0d exp 3", retired); end
    n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL seq_fault got %b exp 0", fault); end
  endtask

  task automatic test_branch();
    for (int k = 0; k < 2; k++) begin
      do_reset();
      drive(1'b1, 3'd0, 32'd0, 26'd0, 32'd0, 32'd0);
      repeat (4) tick();
      n_tests++; if (pc !== 32'h3010) begin n_fail++; $display("FAIL br_setup got %h exp 00003010", pc); end
      drive(1'b1, 3'd1, 32'hFFFF_FFF8, 26'd0, 32'd5, (k == 0) ? 32'd5 : 32'd6);
      #1;
      n_tests++; if (branch_taken !== (k == 0)) begin n_fail++; $display("FAIL br_taken[%0d] got %b exp %b", k, branch_taken, k == 0); end
      n_tests++; if (npc !== ((k == 0) ? 32'h300C : 32'h3014)) begin n_fail++; $display("FAIL br_npc[%0d] got %h", k, npc); end
      tick();
      n_tests++; if (pc !== ((k == 0) ? 32'h300C : 32'h3014)) begin n_fail++; $display("FAIL br_pc[%0d] got %h", k, pc); end
    end
    // bne with equal operands is not taken
    drive(1'b1, 3'd2, 32'h0000_0040, 26'd0, 32'd7, 32'd7);
    #1;
    n_tests++; if (branch_taken !== 1'b0 || npc !== 32'h3018) begin n_fail++; $display("FAIL bne_eq got %b/%h exp 0/00003018", branch_taken, npc); end
  endtask

  task automatic test_jump();
    do_reset();
    drive(1'b1, 3'd3, 32'd0, 26'h0000C05, 32'd0, 32'd0);
    #1;
    n_tests++; if (npc !== 32'h3014) begin n_fail++; $display("FAIL j_npc got %h exp 00003014", npc); end
    n_tests++; if (branch_taken !== 1'b0) begin n_fail++; $display("FAIL j_taken got %b exp 0", branch_taken); end
    tick();
    n_tests++; if (pc !== 32'h3014) begin n_fail++; $display("FAIL j_pc got %h exp 00003014", pc); end
  endtask

  task automatic test_fault_misaligned();
    do_reset();
    drive(1'b1, 3'd0, 32'd0, 26'd0, 32'd0, 32'd0);
    tick();
    drive(1'b1, 3'd4, 32'd0, 26'd0, 32'h3002, 32'd0);
    tick();
    n_tests++; if (fault !== 1'b1) begin n_fail++; $display("FAIL mis_fault got %b exp 1", fault); end
    n_tests++; if (pc !== 32'h3004) begin n_fail++; $display("FAIL mis_pc got %h exp 00003004", pc); end
    n_tests++; if (retired !== 32'd1) begin n_fail++; $display("FAIL mis_retired got %0d exp 1", retired); end
    drive(1'b1, 3'd0, 32'd0, 26'd0, 32'd0, 32'd0);
    repeat (3) tick();
    n_tests++; if (pc !== 32'h3004 || retired !== 32'd1 || fault !== 1'b1) begin n_fail++; $display("FAIL mis_hold got pc=%h ret=%0d f=%b", pc, retired, fault); end
    do_reset();
    #1;
    n_tests++; if (pc !== 32'h3000 || fault !== 1'b0) begin n_fail++; $display("FAIL mis_rst got pc=%h f=%b", pc, fault); end
  endtask

  task automatic test_fault_range();
    logic [31:0] bad [2];
    bad = '{32'h4000, 32'h2FFC};
    for (int k = 0; k < 2; k++) begin
      do_reset();
      drive(1'b1, 3'd4, 32'd0, 26'd0, bad[k], 32'd0);
      tick();
      n_tests++; if (fault !== 1'b1 || pc !== 32'h3000) begin n_fail++; $display("FAIL range_fault[%0d] got f=%b pc=%h exp 1/00003000", k, fault, pc); end
    end
    do_reset();
    drive(1'b1, 3'd4, 32'd0, 26'd0, 32'h3FFC, 32'd0);
    tick();
    n_tests++; if (fault !== 1'b0 || pc !== 32'h3FFC) begin n_fail++; $display("FAIL range_top got f=%b pc=%h exp 0/00003ffc", fault, pc); end
    // a reserved op at the top of memory wraps to 0x4000 and faults
    drive(1'b1, 3'd6, 32'd0, 26'd0, 32'h3000, 32'd0);
    tick();
    n_tests++; if (fault !== 1'b1 || pc !== 32'h3FFC) begin n_fail++; $display("FAIL range_end got f=%b pc=%h exp 1/00003ffc", fault, pc); end
  endtask

  task automatic test_stall_async_reset();
    do_reset();
    drive(1'b1, 3'd0, 32'd0, 26'd0, 32'd0, 32'd0);
    repeat (2) tick();
    drive(1'b0, 3'd3, 32'd0, 26'h0000C40, 32'd0, 32'd0);
    repeat (4) tick();
    n_tests++; if (pc !== 32'h3008 || retired !== 32'd2) begin n_fail++; $display("FAIL stall_hold got pc=%h ret=%0d exp 00003008/2", pc, retired); end
    // a stalled cycle with an illegal target must not raise the fault
    drive(1'b0, 3'd4, 32'd0, 26'd0, 32'h0000_0001, 32'd0);
    repeat (2) tick();
    n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL stall_nofault got %b exp 0", fault); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (pc !== 32'h3000 || retired !== 32'd0) begin n_fail++; $display("FAIL async_rst got pc=%h ret=%0d exp 00003000/0", pc, retired); end
    m_pc = 32'h3000; m_ret = 0; m_fault = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] e_npc;
    logic [31:0] off;
    for (int c = 0; c < 400; c++) begin
      if (m_fault && $urandom_range(0, 3) == 0) do_reset();
      en          = ($urandom_range(0, 99) < 85);
      npc_op      = 3'($urandom_range(0, 7));
      off         = 32'($urandom_range(0, 63)) - 32'd32;
      ext_imm     = off << 2;
      instr_index = ($urandom_range(0, 9) != 0) ? 26'(32'hC00 + $urandom_range(0, 1023)) : 26'($urandom);
      rs_val      = ($urandom_range(0, 9) != 0) ? 32'h3000 + 32'($urandom_range(0, 1023)) * 4 : $urandom;
      rt_val      = $urandom_range(0, 1) ? rs_val : $urandom;
      #1;
      e_npc = ref_npc();
      n_tests++; if (npc !== e_npc || branch_taken !== ref_taken() || pc_plus4 !== m_pc + 32'd4) begin
        n_fail++; $display("FAIL rnd_comb[%0d] op=%0d got npc=%h tk=%b p4=%h exp npc=%h tk=%b", c, npc_op, npc, branch_taken, pc_plus4, e_npc, ref_taken());
      end
      tick();
      n_tests++; if (pc !== m_pc || retired !== m_ret || fault !== m_fault) begin
        n_fail++; $display("FAIL rnd_state[%0d] got pc=%h ret=%0d f=%b exp pc=%h ret=%0d f=%b", c, pc, retired, fault, m_pc, m_ret, m_fault);
      end
    end
  endtask

  initial begin
    m_pc = 32'h3000; m_ret = 0; m_fault = 1'b0;
    test_reset();
    test_seq();
    test_branch();
    test_jump();
    test_fault_misaligned();
    test_fault_range();
    test_stall_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
